// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: bus address map, status layout, FSM encodings.
package uart_tx_buffered_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STAT_W = 3;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // STATUS register layout, MSB first: overflow[2], full[1], busy[0]
    typedef struct packed {
        logic overflow;
        logic full;
        logic busy;
    } uart_status_t;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers; shared by tx and a future rx path.
module uart_tx_buffered_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

    // Full/empty come from pre-edge pointers, so a push while full is dropped even with a pop
    always_comb begin
        push_ok  = push && !full_c;
        pop_ok   = pop && !empty_c;
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bus writes fill a FIFO, a baud-timed FSM sends 8N1 LSB first.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic              io_addr,
    input  logic [DATA_W-1:0] io_din,
    output logic [DATA_W-1:0] io_dout,
    output logic              tx
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [DATA_W-1:0] io_dout_q, io_dout_d;
    logic              ovf_q, ovf_d;

    logic              push_c;
    logic              pop_c;
    logic              bit_end_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [BYTE_W-1:0] fifo_rd_data_c;
    uart_status_t      status_c;

    assign io_dout = io_dout_q;
    assign tx      = tx_q;

    uart_tx_buffered_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .wr_data   (io_din[BYTE_W-1:0]),
        .pop       (pop_c),
        .rd_data_c (fifo_rd_data_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = pop_c ? ^fifo_rd_data_c : parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Bus side: FIFO push, sticky overflow, registered read data
    always_comb begin
        push_c    = io_wr && (io_addr == ADDR_DATA) && !fifo_full_c;
        status_c  = '{overflow: ovf_q, full: fifo_full_c, busy: !fifo_empty_c || (state_q != ST_IDLE)};
        ovf_d     = ovf_q;
        io_dout_d = io_dout_q;
        if (io_rd && (io_addr == ADDR_STATUS)) begin
            ovf_d = 1'b0;
        end
        if (io_wr && (io_addr == ADDR_DATA) && fifo_full_c) begin
            ovf_d = 1'b1;
        end
        if (io_rd) begin
            io_dout_d = (io_addr == ADDR_STATUS) ? DATA_W'(status_c) : '0;
        end
    end

    // Serialiser: each line bit holds for BAUD_DIV cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_c     = 1'b0;
        bit_end_c = (cnt_q == CNT_W'(BAUD_DIV - 1));
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rd_data_c;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end_c) begin
                    cnt_d     = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end_c) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end_c) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            io_dout_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            io_dout_q <= io_dout_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 50 MHz / 115200 baud (434 cycles per bit).
module tb_uart_tx_buffered;

    localparam int unsigned BIT_CYC  = 434;
    localparam int unsigned HALF_CYC = 217;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       io_wr;
    logic       io_rd;
    logic       io_addr;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       tx;

    int n_checks = 0;
    int n_pass   = 0;

    always #10 clk = ~clk;

    uart_tx_buffered #(
        .CLK_HZ     (50_000_000),
        .BAUD       (115_200),
        .FIFO_DEPTH (16),
        .DATA_W     (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_wr   (io_wr),
        .io_rd   (io_rd),
        .io_addr (io_addr),
        .io_din  (io_din),
        .io_dout (io_dout),
        .tx      (tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        io_wr   = 1'b1;
        io_addr = a;
        io_din  = d;
        @(negedge clk);
        io_wr   = 1'b0;
    endtask

    task automatic bus_read(input logic a);
        io_rd   = 1'b1;
        io_addr = a;
        @(negedge clk);
        io_rd   = 1'b0;
    endtask

    // Entered 'pre' cycles after the first start-bit cycle; samples each bit mid-period
    task automatic rx_frame(input int pre, output logic [7:0] b);
        logic [7:0] v;
        v = '0;
        repeat (HALF_CYC - pre) @(negedge clk);
        check("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) @(negedge clk);
            v[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BIT_CYC) @(negedge clk);
        check("parity_bit", 32'(tx), 32'(^v));
`endif
        repeat (BIT_CYC) @(negedge clk);
        check("stop_bit", 32'(tx), 32'd1);
        b = v;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [7:0] b;
        int         n;
        int         lows;

        rst_n   = 1'b0;
        io_wr   = 1'b0;
        io_rd   = 1'b0;
        io_addr = 1'b0;
        io_din  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_dout", 32'(io_dout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(1'b1);
        check("rst_status", 32'(io_dout), 32'h0);

        // single frame 0x55 and two-edge latency
        bus_write(1'b0, 8'h55);
        check("t2_tx_before", 32'(tx), 32'd1);
        @(negedge clk);
        check("t2_tx_fall", 32'(tx), 32'd0);
        rx_frame(0, b);
        check("t2_byte", 32'(b), 32'h55);
        repeat (HALF_CYC) @(negedge clk);
        bus_read(1'b1);
        check("t2_status_idle", 32'(io_dout), 32'h0);

        // three back-to-back frames with one idle cycle between
        bus_write(1'b0, 8'hA1);
        bus_write(1'b0, 8'hB2);
        bus_write(1'b0, 8'hC3);
        rx_frame(1, b);
        check("t3_byte0", 32'(b), 32'hA1);
        wait_fall(n);
        check("t3_gap0", 32'(n), 32'(HALF_CYC + 1));
        rx_frame(0, b);
        check("t3_byte1", 32'(b), 32'hB2);
        wait_fall(n);
        check("t3_gap1", 32'(n), 32'(HALF_CYC + 1));
        rx_frame(0, b);
        check("t3_byte2", 32'(b), 32'hC3);
        repeat (HALF_CYC + 1) @(negedge clk);

        // overflow: 18 writes, 17 accepted, 18th dropped
        for (int i = 0; i < 18; i++) begin
            bus_write(1'b0, 8'(i));
        end
        bus_read(1'b0);
        check("t4_data_read", 32'(io_dout), 32'h0);
        bus_read(1'b1);
        check("t4_status_ovf", 32'(io_dout), 32'h7);
        bus_read(1'b1);
        check("t4_status_clr", 32'(io_dout), 32'h3);

        // reset during a data bit of byte 0x00
        repeat (1000) @(negedge clk);
        check("t5_tx_data", 32'(tx), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("t5_tx_async", 32'(tx), 32'd1);
        check("t5_dout_async", 32'(io_dout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_write(1'b1, 8'hFF);
        bus_read(1'b1);
        check("t5_status_after", 32'(io_dout), 32'h0);
        lows = 0;
        repeat (5000) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        check("t5_no_frames", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
        bus_write(1'b0, 8'h07);
        @(negedge clk);
        check("t6_tx_fall", 32'(tx), 32'd0);
        rx_frame(0, b);
        check("t6_byte", 32'(b), 32'h07);
        repeat (HALF_CYC) @(negedge clk);
        bus_read(1'b1);
        check("t6_status_idle", 32'(io_dout), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
